// File: rtl/me_control.sv
// me_control: full-search motion estimator sequencer.
// Steps 256 candidate vectors across 16 staggered PEs.
module me_control (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        compstart,
  output logic [15:0] peready,
  output logic [15:0] pe_start,
  output logic [3:0]  vectorx,
  output logic [3:0]  vectory,
  output logic [7:0]  addressR,
  output logic [9:0]  addressS1,
  output logic [9:0]  addressS2,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    RUN,
    DONE,
    HOLD
  } state_t;

  localparam logic [12:0] LAST  = 13'd4111;
  localparam logic [12:0] FIRST = 13'd256;

  state_t      state;
  state_t      state_nxt;
  logic [12:0] count;

  logic [3:0] r;
  logic [3:0] prow;
  logic [3:0] pcol;
  logic [4:0] srow;
  logic       scan;
  logic       ready_win;

  assign r    = count[11:8];
  assign prow = count[7:4];
  assign pcol = count[3:0];

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      count <= '0;
    end else begin
      state <= state_nxt;
      if (state == RUN) count <= count + 13'd1;
      else              count <= '0;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = CLEAR;
      HOLD:    if (start) state_nxt = CLEAR;
      CLEAR:   state_nxt = RUN;
      RUN:     if (count == LAST) state_nxt = DONE;
      DONE:    state_nxt = HOLD;
      default: state_nxt = IDLE;
    endcase
  end

  // Last 16 RUN cycles only drain readies; no new fetches.
  always_comb begin
    compstart = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    peready   = '0;
    pe_start  = '0;
    vectorx   = '0;
    vectory   = '0;
    addressR  = '0;
    addressS1 = '0;
    addressS2 = '0;
    srow      = {1'b0, r} + {1'b0, prow};
    scan      = (state == RUN) && !count[12];
    ready_win = (state == RUN) && (count >= FIRST)
                && (count <= LAST);

    unique case (1'b1)
      state == CLEAR: busy = 1'b1;
      state == RUN: begin
        busy      = 1'b1;
        compstart = 1'b1;
      end
      state == DONE: begin
        busy      = 1'b1;
        compstart = 1'b1;
        done      = 1'b1;
      end
      state == HOLD: compstart = 1'b1;
      default: ;
    endcase

    if (scan) begin
      addressR  = count[7:0];
      addressS1 = {srow, 1'b0, pcol};
      addressS2 = {srow, 1'b1, pcol};
      if (prow == 4'd0) pe_start[pcol] = 1'b1;
    end

    if (ready_win && prow == 4'd0) begin
      peready[pcol] = 1'b1;
      vectorx       = pcol;
      vectory       = r - 4'd1;
    end
  end

endmodule

// File: tb/tb_me_control.sv
// tb_me_control: scoreboard bench for me_control.
// Stimulus queues expected pulses; a monitor pops them.
`timescale 1ns/1ps
module tb_me_control;

  logic        clock;
  logic        reset;
  logic        start;
  logic        compstart;
  logic [15:0] peready;
  logic [15:0] pe_start;
  logic [3:0]  vectorx;
  logic [3:0]  vectory;
  logic [7:0]  addressR;
  logic [9:0]  addressS1;
  logic [9:0]  addressS2;
  logic        busy;
  logic        done;

  me_control dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .compstart (compstart),
    .peready   (peready),
    .pe_start  (pe_start),
    .vectorx   (vectorx),
    .vectory   (vectory),
    .addressR  (addressR),
    .addressS1 (addressS1),
    .addressS2 (addressS2),
    .busy      (busy),
    .done      (done)
  );

  typedef struct {
    int unsigned cyc;
    logic [15:0] val;
    logic [3:0]  vx;
    logic [3:0]  vy;
  } exp_t;

  exp_t rq[$];
  exp_t pq[$];
  exp_t dq[$];

  int unsigned cyc;
  int unsigned base;
  int          n_cmp;
  int          n_bad;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name,
                       input logic [79:0] act,
                       input logic [79:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [79:0] outs();
    return {9'd0, compstart, peready, pe_start, vectorx,
            vectory, addressR, addressS1, addressS2,
            busy, done};
  endfunction

  // Monitor: pops expectations whenever the DUT pulses.
  always @(negedge clock) begin
    exp_t e;
    if (peready != 16'd0) begin
      if (rq.size() == 0) begin
        check("peready_unexpected", {cyc, peready}, 0);
      end else begin
        e = rq.pop_front();
        check("peready", {cyc, peready, vectorx, vectory},
              {e.cyc, e.val, e.vx, e.vy});
      end
    end else begin
      check("vector_idle", {vectorx, vectory}, 0);
    end
    if (pe_start != 16'd0) begin
      if (pq.size() == 0) begin
        check("pe_start_unexpected", {cyc, pe_start}, 0);
      end else begin
        e = pq.pop_front();
        check("pe_start", {cyc, pe_start}, {e.cyc, e.val});
      end
    end
    if (done) begin
      if (dq.size() == 0) begin
        check("done_unexpected", cyc, 0);
      end else begin
        e = dq.pop_front();
        check("done_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic push_search();
    for (int r = 0; r < 16; r++)
      for (int k = 0; k < 16; k++)
        pq.push_back('{base + 256 * r + k,
                       16'd1 << k, 4'd0, 4'd0});
    for (int y = 0; y < 16; y++)
      for (int k = 0; k < 16; k++)
        rq.push_back('{base + 256 * (y + 1) + k,
                       16'd1 << k, 4'(k), 4'(y)});
    dq.push_back('{base + 4112, 16'd0, 4'd0, 4'd0});
  endtask

  task automatic launch(input logic cs_before);
    @(negedge clock);
    check("pre_start_compstart", compstart, cs_before);
    start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    base = cyc + 1;
    push_search();
    @(negedge clock);
    check("clear_compstart", compstart, 0);
    check("clear_busy", busy, 1);
    @(negedge clock);
    check("c0_compstart", compstart, 1);
    check("c0_pe_start", pe_start, 16'h0001);
    check("c0_addressR", addressR, 0);
    check("c0_addressS1", addressS1, 10'h000);
    check("c0_addressS2", addressS2, 10'h010);
  endtask

  task automatic at_count(input int unsigned n);
    while (cyc < base + n) @(negedge clock);
  endtask

  task automatic finish_run();
    at_count(3903);
    check("spot_addressR", addressR, 8'h3F);
    check("spot_addressS1", addressS1, 10'h24F);
    check("spot_addressS2", addressS2, 10'h25F);
    at_count(4096);
    check("drain_addr", {addressR, addressS1, addressS2}, 0);
    check("drain_pe_start", pe_start, 0);
    at_count(4111);
    check("last_peready", {peready, vectorx, vectory},
          {16'h8000, 4'hF, 4'hF});
    at_count(4112);
    check("done_state", {done, busy, compstart, peready},
          {3'b111, 16'd0});
    @(negedge clock);
    check("hold_state", {done, busy, compstart}, 3'b001);
    check("hold_addr", {addressR, addressS1, addressS2}, 0);
    check("queues_empty", rq.size() + pq.size() + dq.size(), 0);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
    base  = 0;
    reset = 1'b1;
    start = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    repeat (10) begin
      @(negedge clock);
      check("idle_outputs", outs(), 0);
    end

    launch(1'b0);
    finish_run();

    launch(1'b1);
    at_count(1000);
    reset = 1'b1;
    rq.delete();
    pq.delete();
    dq.delete();
    @(posedge clock);
    #1 reset = 1'b0;
    repeat (3) begin
      @(negedge clock);
      check("reset_outputs", outs(), 0);
    end

    launch(1'b0);
    at_count(500);
    start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    @(negedge clock);
    check("ignored_start", {busy, compstart, done}, 3'b110);
    finish_run();

    launch(1'b1);
    finish_run();

    repeat (2) @(negedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
